// File: rtl/tx_gearbox_66_64.sv
// Transmit 66b->64b gearbox: packs {tdata, ttype} blocks LSB-first into a continuous
// 64-bit word stream, using input backpressure to absorb the 33:32 rate difference.
module tx_gearbox_66_64 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  s_axis_ttype,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        ttype_err
);

  logic [191:0] store_q, store_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         ttype_err_q, ttype_err_d;

  logic         in_fire;
  logic         out_fire;
  logic [7:0]   base;
  logic [191:0] shifted;
  logic [191:0] blk_ext;

  // Outputs depend on registered state only, so there is no ready->ready path.
  assign m_axis_tvalid = (cnt_q >= 8'd64);
  assign m_axis_tdata  = store_q[63:0];
  assign s_axis_tready = (cnt_q < 8'd128);
  assign ttype_err     = ttype_err_q;

  always_comb begin
    in_fire     = s_axis_tvalid & s_axis_tready;
    out_fire    = m_axis_tvalid & m_axis_tready;
    base        = cnt_q - (out_fire ? 8'd64 : 8'd0);
    shifted     = out_fire ? (store_q >> 64) : store_q;
    blk_ext     = {126'd0, s_axis_tdata, s_axis_ttype};
    store_d     = shifted;
    // Bits above the valid count are always zero, so OR-in places the block exactly.
    if (in_fire) begin
      store_d = shifted | (blk_ext << base);
    end
    cnt_d       = base + (in_fire ? 8'd66 : 8'd0);
    ttype_err_d = in_fire & (s_axis_ttype[1] == s_axis_ttype[0]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      store_q     <= '0;
      cnt_q       <= '0;
      ttype_err_q <= 1'b0;
    end else begin
      store_q     <= store_d;
      cnt_q       <= cnt_d;
      ttype_err_q <= ttype_err_d;
    end
  end

endmodule

// File: tb/tb_tx_gearbox_66_64.sv
// Directed bench for tx_gearbox_66_64; a bit-queue reference tracks the serial stream.
module tb_tx_gearbox_66_64;

  logic        clk;
  logic        reset_n;
  logic [1:0]  s_ttype;
  logic [63:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        ttype_err;

  tx_gearbox_66_64 dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .s_axis_ttype  (s_ttype),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .ttype_err     (ttype_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec;
  int          n_miss;
  int          n_words;
  bit          q[$];
  logic        err_exp;
  logic        hold_valid;
  logic [63:0] hold_data;
  logic        last_in_fire;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic new_block(input bit allow_bad);
    s_tdata = {$urandom, $urandom};
    if (allow_bad && $urandom_range(15) == 0) s_ttype = ($urandom_range(1) == 0) ? 2'b00 : 2'b11;
    else s_ttype = ($urandom_range(1) == 0) ? 2'b01 : 2'b10;
  endtask

  // Sample at the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    logic        inf;
    logic        outf;
    logic [63:0] w;
    logic [65:0] blk;
    @(negedge clk);
    inf = s_tvalid & s_tready;
    outf = m_tvalid & m_tready;
    last_in_fire = inf;
    if (reset_n) begin
      check("ttype_err", 64'(ttype_err), 64'(err_exp));
      check("s_tready", 64'(s_tready), 64'(q.size() < 128));
      check("m_tvalid", 64'(m_tvalid), 64'(q.size() >= 64));
      if (hold_valid) begin
        check("hold_tvalid", 64'(m_tvalid), 64'd1);
        check("hold_tdata", m_tdata, hold_data);
      end
      hold_valid = m_tvalid & ~m_tready;
      hold_data  = m_tdata;
      err_exp    = inf & (s_ttype == 2'b00 || s_ttype == 2'b11);
      if (outf) begin
        if (q.size() < 64) begin
          check("underflow", 64'(q.size()), 64'd64);
        end else begin
          for (int i = 0; i < 64; i++) w[i] = q.pop_front();
          check("word", m_tdata, w);
        end
        n_words++;
      end
      if (inf) begin
        blk = {s_tdata, s_ttype};
        for (int i = 0; i < 66; i++) q.push_back(blk[i]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tdata", m_tdata, 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd1);
    check("rst_ttype_err", 64'(ttype_err), 64'd0);
    q.delete();
    err_exp    = 1'b0;
    hold_valid = 1'b0;
    s_tvalid   = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_random(input int nblk, input int pv, input int pr, input int budget);
    int sent = 0;
    int c = 0;
    s_tvalid = 1'b0;
    while ((sent < nblk || q.size() >= 64) && c < budget) begin
      if (!s_tvalid && sent < nblk && $urandom_range(99) < pv) begin
        new_block(1'b1);
        s_tvalid = 1'b1;
      end
      m_tready = ($urandom_range(99) < pr);
      tick();
      c++;
      if (last_in_fire) begin
        sent++;
        s_tvalid = 1'b0;
      end
    end
    s_tvalid = 1'b0;
    check("budget", 64'(c < budget), 64'd1);
  endtask

  initial begin
    int sent;
    int acc;
    int w0;
    n_vec = 0; n_miss = 0; n_words = 0;
    reset_n = 1'b1; s_tvalid = 1'b0; m_tready = 1'b0;
    s_ttype = 2'b01; s_tdata = '0;
    err_exp = 1'b0; hold_valid = 1'b0; hold_data = '0; last_in_fire = 1'b0;
    #2;
    apply_reset();

    // Hand-computed packing of two blocks.
    s_ttype = 2'b01; s_tdata = 64'hFFFF_FFFF_FFFF_FFFF; s_tvalid = 1'b1; m_tready = 1'b0;
    tick();
    check("pack_w0", m_tdata, 64'hFFFF_FFFF_FFFF_FFFD);
    s_ttype = 2'b10; s_tdata = 64'd0; m_tready = 1'b1;
    tick();
    check("pack_w1", m_tdata, 64'h0000_0000_0000_000B);
    s_tvalid = 1'b0;
    tick();

    // Rate matching: 64 blocks at full rate, tready low only at cycles 32 and 65.
    apply_reset();
    sent = 0; w0 = n_words; m_tready = 1'b1;
    new_block(1'b0);
    for (int c = 0; c < 80; c++) begin
      s_tvalid = (sent < 64);
      check("rate_tready", 64'(s_tready), 64'(!(c == 32 || c == 65)));
      tick();
      if (last_in_fire) begin
        sent++;
        new_block(1'b0);
      end
    end
    s_tvalid = 1'b0;
    check("rate_blocks", 64'(sent), 64'd64);
    check("rate_words", 64'(n_words - w0), 64'd66);
    check("rate_tvalid_end", 64'(m_tvalid), 64'd0);

    // Mid-stream reset at cnt = 100 (18 blocks in, 17 words out).
    apply_reset();
    m_tready = 1'b1;
    new_block(1'b0);
    for (int c = 0; c < 18; c++) begin
      s_tvalid = 1'b1;
      tick();
      if (last_in_fire) new_block(1'b0);
    end
    s_tvalid = 1'b0;
    check("pre_rst_tvalid", 64'(m_tvalid), 64'd1);
    apply_reset();
    m_tready = 1'b0;
    s_ttype = 2'b10; s_tdata = 64'h0123_4567_89AB_CDEF; s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
    check("post_rst_w0", m_tdata, {s_tdata[61:0], 2'b10});
    tick();

    // Output backpressure for 10 cycles.
    apply_reset();
    m_tready = 1'b0; acc = 0;
    new_block(1'b0);
    for (int c = 0; c < 10; c++) begin
      s_tvalid = 1'b1;
      tick();
      if (last_in_fire) begin
        acc++;
        new_block(1'b0);
      end
    end
    s_tvalid = 1'b0;
    check("bp_accepted", 64'(acc), 64'd2);
    check("bp_s_tready", 64'(s_tready), 64'd0);
    run_random(0, 0, 100, 50);
    check("bp_drained", 64'(q.size()), 64'd4);

    // Illegal header pulses ttype_err for one cycle.
    apply_reset();
    m_tready = 1'b0;
    s_ttype = 2'b11; s_tdata = 64'hA5A5_0000_FFFF_1234; s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
    check("err_pulse", 64'(ttype_err), 64'd1);
    check("err_hdr_bits", 64'(m_tdata[1:0]), 64'd3);
    tick();
    check("err_clear", 64'(ttype_err), 64'd0);

    // Random valid/ready toggling.
    apply_reset();
    run_random(10000, 70, 75, 40000);
    run_random(0, 0, 100, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/tx_gearbox_66_64.md
# tx_gearbox_66_64

Transmit-side 66b→64b gearbox for the 64b/66b PCS. Accepts one 66-bit block per beat (2-bit sync header `ttype` plus 64-bit payload) from the encoder over AXI Stream. Packs the blocks back-to-back into a continuous 64-bit word stream for the serializer. It is the inverse of the receive-side block synchronizer: 32 input blocks produce exactly 33 output words, and input backpressure absorbs the rate difference.

## Interface
- Parameters: none.
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s_axis_ttype`  in  2  sync header of the input block; legal values are 2'b01 (data) and 2'b10 (control).
- `s_axis_tdata`  in  64  block payload.
- `s_axis_tvalid`  in  1  input block valid.
- `s_axis_tready`  out  1  block accepted when high with tvalid.
- `m_axis_tdata`  out  64  packed word; bit 0 is transmitted first.
- `m_axis_tvalid`  out  1  output word valid.
- `m_axis_tready`  in  1  downstream ready.
- `ttype_err`  out  1  one-cycle pulse: an accepted block carried ttype 2'b00 or 2'b11.

## Operation
- Serial order is LSB first. Each block is the 66-bit vector `{tdata, ttype}`, so the header goes first, header bit 0 leading.
- State:
  - `buf[191:0]`: bit store; valid bits occupy `buf[cnt-1:0]`, all bits above `cnt` are held at 0.
  - `cnt[7:0]`: valid bit count, always even, range 0..192.
- `in_fire = s_axis_tvalid & s_axis_tready`; `out_fire = m_axis_tvalid & m_axis_tready`.
- Combinational outputs from registered state only (no ready→ready or valid→ready path):
  - `m_axis_tvalid = (cnt >= 64)`
  - `m_axis_tdata = buf[63:0]`
  - `s_axis_tready = (cnt < 128)`
- Per-clock update:
  - `base = cnt - (out_fire ? 64 : 0)`
  - `sh = out_fire ? buf >> 64 : buf`
  - If `in_fire`: `sh[base +: 66] = {s_axis_tdata, s_axis_ttype}`.
  - `buf <= sh`; `cnt <= base + (in_fire ? 66 : 0)`.
- Maximum `cnt` is 126 + 66 = 192, so the store never overflows. `cnt` never underflows because `out_fire` requires `cnt >= 64`.
- Blocks with an illegal ttype are packed unchanged. `ttype_err` is registered: it goes high the cycle after the accepting edge, for one cycle per offending block.
- Reset (async assert, any time, including mid-block or mid-stall):
  - `buf = 0`, `cnt = 0`, `ttype_err = 0`.
  - Therefore `m_axis_tvalid = 0`, `m_axis_tdata = 0`, `s_axis_tready = 1`.
  - Partially packed bits are discarded.
- There is no frame or alignment state. Output word boundaries start fresh from bit 0 of the first block after reset.

## Timing
- Latency: a block accepted at edge N appears at the head of `m_axis_tdata` with `m_axis_tvalid = 1` from cycle N+1, provided `cnt` was 0 before the edge.
- Steady-state throughput with `s_axis_tvalid = m_axis_tready = 1` from reset:
  - Blocks are accepted at cycles 0..31.
  - `s_axis_tready` is low for exactly cycle 32, when `cnt = 128`.
  - Words are output at cycles 1..33.
  - `cnt` returns to 0 after cycle 33, and the pattern repeats with period 33.
- AXI rules:
  - While `m_axis_tvalid = 1` and `m_axis_tready = 0`, `m_axis_tdata` holds stable.
  - `m_axis_tvalid` never drops without `out_fire`.
  - Inputs are sampled only on `in_fire`.
- Simultaneous in and out is the normal case: net `cnt` change is +2.
- Output stall with input flowing: `cnt` grows by 66 per block until `cnt >= 128`, then `s_axis_tready` deasserts.
- Input idle: output drains while `cnt >= 64`. Residual bits (< 64) wait for the next block.

## Test plan
- **Reset:** assert `reset_n = 0` mid-stream with `cnt = 100` → same cycle: `m_axis_tvalid = 0`, `m_axis_tdata = 0`, `s_axis_tready = 1`, `ttype_err = 0`. After release, the first word is built from the next block only.
- **Packing values:** block0 `ttype = 01`, `tdata = 64'hFFFF_FFFF_FFFF_FFFF` → word0 = 64'hFFFF_FFFF_FFFF_FFFD. Then block1 `ttype = 10`, `tdata = 0` → word1 = 64'h0000_0000_0000_000B.
- **Rate matching:** 64 random blocks, continuous valid/ready → 66 words matching a bit-serial reference model. `s_axis_tready` is low exactly at cycles 32 and 65.
- **Output backpressure:** `m_axis_tready = 0` for 10 cycles with input valid → exactly 2 blocks accepted (`cnt` 0→66→132). `s_axis_tready = 0` afterwards. `m_axis_tdata` is stable throughout. Stream is lossless after release.
- **Illegal header:** block with `ttype = 2'b11` → `ttype_err` high for one cycle, one cycle after acceptance. Bits 1:0 of the corresponding stream position equal 2'b11.
- **Random valid/ready toggling:** 10k blocks → output bitstream equals the concatenation of `{tdata, ttype}`. No AXI protocol violations.
